// File: rtl/pwm_multimode_core.sv
// pwm_multimode_core: multi-channel edge/center-aligned PWM with shadowed period/duty/mode and one shared prescaler.
// Optional complementary outputs with dead-time insertion are built when PWM_DEADTIME_EN is defined.
module pwm_multimode_core #(
  parameter int NUM_CHANNELS    = 4,
  parameter int REG_WIDTH       = 16,
  parameter int PRESCALER_WIDTH = 16,
  parameter int DEAD_TIME_WIDTH = 8,
  localparam int WDATA_WIDTH    = (REG_WIDTH > PRESCALER_WIDTH) ? REG_WIDTH : PRESCALER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_cfg_we,
  input  logic [3:0]              i_cfg_ch,
  input  logic [1:0]              i_cfg_sel,
  input  logic [WDATA_WIDTH-1:0]  i_cfg_wdata,
  output logic [NUM_CHANNELS-1:0] o_pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic [NUM_CHANNELS-1:0] o_pwm_out_n,
`endif
  output logic [NUM_CHANNELS-1:0] o_period_end,
  output logic [NUM_CHANNELS-1:0] o_pending
);

  localparam logic [PRESCALER_WIDTH-1:0] PRE_ONE  = {{(PRESCALER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0]       CNT_ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                       DIR_UP   = 1'b0;
  localparam logic                       DIR_DOWN = 1'b1;

  logic [PRESCALER_WIDTH-1:0] r_pre_cnt;
  logic [PRESCALER_WIDTH-1:0] r_pre_active;
  logic [PRESCALER_WIDTH-1:0] r_pre_shadow;
  logic                       w_tick;
  logic                       w_pre_wr;

`ifdef PWM_DEADTIME_EN
  logic [DEAD_TIME_WIDTH-1:0] r_dt_active;
  logic [DEAD_TIME_WIDTH-1:0] r_dt_shadow;
  logic                       w_dt_wr;

  assign w_dt_wr  = i_cfg_we && (i_cfg_sel == 2'd3) && (i_cfg_ch == 4'd15);
  assign w_pre_wr = i_cfg_we && (i_cfg_sel == 2'd3) && (i_cfg_ch != 4'd15);
`else
  assign w_pre_wr = i_cfg_we && (i_cfg_sel == 2'd3);
`endif

  assign w_tick = i_enable && (r_pre_cnt == r_pre_active);

  // Shared prescaler; global shadows are taken on every tick and continuously while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt    <= '0;
      r_pre_active <= '0;
      r_pre_shadow <= '0;
`ifdef PWM_DEADTIME_EN
      r_dt_active  <= '0;
      r_dt_shadow  <= '0;
`endif
    end else begin
      if (w_pre_wr) begin
        r_pre_shadow <= i_cfg_wdata[PRESCALER_WIDTH-1:0];
      end
      if (!i_enable || w_tick) begin
        r_pre_cnt    <= '0;
        r_pre_active <= r_pre_shadow;
      end else begin
        r_pre_cnt    <= r_pre_cnt + PRE_ONE;
      end
`ifdef PWM_DEADTIME_EN
      if (w_dt_wr) begin
        r_dt_shadow <= i_cfg_wdata[DEAD_TIME_WIDTH-1:0];
      end
      if (!i_enable || w_tick) begin
        r_dt_active <= r_dt_shadow;
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [REG_WIDTH-1:0] r_period_sh, r_duty_sh, r_period_a, r_duty_a, r_cnt;
    logic [REG_WIDTH-1:0] w_step_cnt, w_cnt_next;
    logic [1:0]           r_mode_sh, r_mode_a;
    logic                 r_dir, w_step_dir, w_dir_next, w_boundary, w_restart;
    logic                 w_raw, w_wr_hit, r_pwm, r_period_end, r_pending;

    assign w_wr_hit = i_cfg_we && (i_cfg_sel != 2'd3) && (i_cfg_ch == 4'(g));
    assign w_raw    = (r_cnt < r_duty_a);

    // Counter step for the active mode; center mode walks up to period and back, boundary at 0 going down.
    always_comb begin
      w_boundary = 1'b0;
      w_step_cnt = r_cnt;
      w_step_dir = r_dir;
      if (!w_tick) begin
        w_boundary = 1'b0;
      end else if (!r_mode_a[0]) begin
        if (r_cnt == r_period_a) begin
          w_boundary = 1'b1;
          w_step_cnt = '0;
        end else begin
          w_step_cnt = r_cnt + CNT_ONE;
        end
      end else if (r_period_a == '0) begin
        w_boundary = 1'b1;
        w_step_cnt = '0;
        w_step_dir = DIR_UP;
      end else if (r_dir == DIR_UP) begin
        if (r_cnt == r_period_a) begin
          w_step_dir = DIR_DOWN;
          w_step_cnt = r_cnt - CNT_ONE;
        end else begin
          w_step_cnt = r_cnt + CNT_ONE;
        end
      end else begin
        if (r_cnt == '0) begin
          w_boundary = 1'b1;
          w_step_dir = DIR_UP;
          w_step_cnt = CNT_ONE;
        end else begin
          w_step_cnt = r_cnt - CNT_ONE;
        end
      end
    end

    // A new mode or a zero period restarts the count from 0, direction up.
    assign w_restart  = w_boundary && ((r_mode_sh != r_mode_a) || (r_period_sh == '0));
    assign w_cnt_next = w_restart ? '0 : w_step_cnt;
    assign w_dir_next = w_restart ? DIR_UP : w_step_dir;

    // Shadow writes, boundary loads and the per-channel counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_period_sh  <= '0;
        r_duty_sh    <= '0;
        r_mode_sh    <= 2'd0;
        r_period_a   <= '0;
        r_duty_a     <= '0;
        r_mode_a     <= 2'd0;
        r_cnt        <= '0;
        r_dir        <= DIR_UP;
        r_pending    <= 1'b0;
        r_period_end <= 1'b0;
      end else begin
        if (w_wr_hit) begin
          case (i_cfg_sel)
            2'd0:    r_period_sh <= i_cfg_wdata[REG_WIDTH-1:0];
            2'd1:    r_duty_sh   <= i_cfg_wdata[REG_WIDTH-1:0];
            2'd2:    r_mode_sh   <= i_cfg_wdata[1:0];
            default: r_mode_sh   <= r_mode_sh;
          endcase
        end
        if (!i_enable) begin
          r_period_a   <= r_period_sh;
          r_duty_a     <= r_duty_sh;
          r_mode_a     <= r_mode_sh;
          r_cnt        <= '0;
          r_dir        <= DIR_UP;
          r_pending    <= 1'b0;
          r_period_end <= 1'b0;
        end else begin
          r_cnt        <= w_cnt_next;
          r_dir        <= w_dir_next;
          r_period_end <= w_boundary;
          r_pending    <= w_wr_hit || (r_pending && !w_boundary);
          if (w_boundary) begin
            r_period_a <= r_period_sh;
            r_duty_a   <= r_duty_sh;
            r_mode_a   <= r_mode_sh;
          end
        end
      end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [DEAD_TIME_WIDTH-1:0] DT_ONE = {{(DEAD_TIME_WIDTH-1){1'b0}}, 1'b1};
    logic [DEAD_TIME_WIDTH-1:0] r_dt_cnt, w_dt_next;
    logic                       r_raw_q, r_pwm_n;

    // Every raw edge restarts the gap, so a pulse shorter than the dead time never reaches a pin.
    always_comb begin
      if (w_raw != r_raw_q) begin
        w_dt_next = r_dt_active;
      end else if (r_dt_cnt != '0) begin
        w_dt_next = r_dt_cnt - DT_ONE;
      end else begin
        w_dt_next = '0;
      end
    end

    // Complementary pin pair; both sit at the inactive (invert) level during a gap or while idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dt_cnt <= '0;
        r_raw_q  <= 1'b0;
        r_pwm    <= 1'b0;
        r_pwm_n  <= 1'b0;
      end else if (!i_enable) begin
        r_dt_cnt <= '0;
        r_raw_q  <= 1'b0;
        r_pwm    <= r_mode_a[1];
        r_pwm_n  <= r_mode_a[1];
      end else begin
        r_dt_cnt <= w_dt_next;
        r_raw_q  <= w_raw;
        if (w_dt_next != '0) begin
          r_pwm   <= r_mode_a[1];
          r_pwm_n <= r_mode_a[1];
        end else begin
          r_pwm   <= w_raw ^ r_mode_a[1];
          r_pwm_n <= ~w_raw ^ r_mode_a[1];
        end
      end
    end

    assign o_pwm_out_n[g] = r_pwm_n;
`else
    // Pin drive, one cycle behind the counter; inactive (invert) level while idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pwm <= 1'b0;
      end else if (!i_enable) begin
        r_pwm <= r_mode_a[1];
      end else begin
        r_pwm <= w_raw ^ r_mode_a[1];
      end
    end
`endif

    assign o_pwm_out[g]    = r_pwm;
    assign o_period_end[g] = r_period_end;
    assign o_pending[g]    = r_pending;
  end

endmodule

// File: tb/tb_pwm_multimode_core.sv
// Self-checking bench for pwm_multimode_core (default build): directed waveform checks plus random traffic vs a position-based model.
module tb_pwm_multimode_core;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_enable;
  logic           i_cfg_we;
  logic [3:0]     i_cfg_ch;
  logic [1:0]     i_cfg_sel;
  logic [15:0]    i_cfg_wdata;
  logic [NCH-1:0] o_pwm_out;
  logic [NCH-1:0] o_period_end;
  logic [NCH-1:0] o_pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position within the period instead of counter+direction.
  int m_per_sh[NCH], m_duty_sh[NCH], m_mode_sh[NCH];
  int m_per_a[NCH], m_duty_a[NCH], m_mode_a[NCH], m_pos[NCH];
  int m_pre_sh, m_pre_a, m_pre_cnt;
  logic [NCH-1:0] m_out, m_pe, m_pend;

  always #5 clk = ~clk;

  pwm_multimode_core #(.NUM_CHANNELS(NCH), .REG_WIDTH(16), .PRESCALER_WIDTH(16), .DEAD_TIME_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_sel(i_cfg_sel), .i_cfg_wdata(i_cfg_wdata), .o_pwm_out(o_pwm_out),
    .o_period_end(o_period_end), .o_pending(o_pending)
  );

  task automatic model_step();
    bit tick, bnd, hit, ctr;
    int c, new_pre_sh;
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_per_sh[ch] = 0; m_duty_sh[ch] = 0; m_mode_sh[ch] = 0;
        m_per_a[ch] = 0; m_duty_a[ch] = 0; m_mode_a[ch] = 0; m_pos[ch] = 0;
      end
      m_pre_sh = 0; m_pre_a = 0; m_pre_cnt = 0;
      m_out = '0; m_pe = '0; m_pend = '0;
    end else begin
      tick = i_enable && (m_pre_cnt == m_pre_a);
      for (int ch = 0; ch < NCH; ch++) begin
        hit = i_cfg_we && (int'(i_cfg_ch) == ch) && (i_cfg_sel != 2'd3);
        ctr = (m_mode_a[ch] % 2) == 1;
        c = (ctr && m_pos[ch] > m_per_a[ch]) ? 2 * m_per_a[ch] - m_pos[ch] : m_pos[ch];
        if (!i_enable) begin
          m_out[ch] = (m_mode_a[ch] >= 2);
          m_pe[ch] = 1'b0; m_pend[ch] = 1'b0;
          m_per_a[ch] = m_per_sh[ch]; m_duty_a[ch] = m_duty_sh[ch]; m_mode_a[ch] = m_mode_sh[ch];
          m_pos[ch] = 0;
        end else begin
          m_out[ch] = (c < m_duty_a[ch]) ^ (m_mode_a[ch] >= 2);
          bnd = tick && (ctr ? (m_pos[ch] == 2 * m_per_a[ch]) : (m_pos[ch] == m_per_a[ch]));
          m_pe[ch] = bnd;
          m_pend[ch] = hit || (m_pend[ch] && !bnd);
          if (bnd) begin
            if (m_mode_sh[ch] != m_mode_a[ch] || m_per_sh[ch] == 0 || (m_mode_sh[ch] % 2) == 0) m_pos[ch] = 0;
            else m_pos[ch] = 1;
            m_per_a[ch] = m_per_sh[ch]; m_duty_a[ch] = m_duty_sh[ch]; m_mode_a[ch] = m_mode_sh[ch];
          end else if (tick) begin
            m_pos[ch] = m_pos[ch] + 1;
          end
        end
        if (hit) begin
          case (i_cfg_sel)
            2'd0: m_per_sh[ch]  = int'(i_cfg_wdata);
            2'd1: m_duty_sh[ch] = int'(i_cfg_wdata);
            2'd2: m_mode_sh[ch] = int'(i_cfg_wdata) % 4;
            default: ;
          endcase
        end
      end
      new_pre_sh = (i_cfg_we && i_cfg_sel == 2'd3) ? int'(i_cfg_wdata) : m_pre_sh;
      if (!i_enable || tick) begin
        m_pre_cnt = 0; m_pre_a = m_pre_sh;
      end else begin
        m_pre_cnt = m_pre_cnt + 1;
      end
      m_pre_sh = new_pre_sh;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic write_cfg(input int ch, input int sel, input int data);
    i_cfg_we = 1'b1; i_cfg_ch = 4'(ch); i_cfg_sel = 2'(sel); i_cfg_wdata = 16'(data);
    cycle();
    i_cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_enable = 1'b0; i_cfg_we = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  // Idle setup of one channel; the trailing idle cycle lets the active copies pick up the shadows.
  task automatic setup_ch(input int ch, input int per, input int duty, input int mode, input int pre);
    i_enable = 1'b0;
    write_cfg(ch, 0, per); write_cfg(ch, 1, duty); write_cfg(ch, 2, mode); write_cfg(ch, 3, pre);
    cycle();
  endtask

  task automatic wait_pe(input int ch, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle();
      if (o_period_end[ch]) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    i_enable = 1'b1; i_cfg_we = 1'b1; i_cfg_ch = 4'd0; i_cfg_sel = 2'd1; i_cfg_wdata = 16'd5;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0; i_cfg_we = 1'b0; i_enable = 1'b0;
    n_checks++; if (o_pwm_out !== 4'b0000) $display("FAIL reset_pwm: got %b expected 0000", o_pwm_out); else n_pass++;
    n_checks++; if (o_period_end !== 4'b0000) $display("FAIL reset_pe: got %b expected 0000", o_period_end); else n_pass++;
    n_checks++; if (o_pending !== 4'b0000) $display("FAIL reset_pending: got %b expected 0000", o_pending); else n_pass++;
  endtask

  task automatic test_edge_mode();
    bit found; int hi, pe_n, pe_at;
    do_reset(); setup_ch(0, 9, 3, 0, 0);
    i_enable = 1'b1;
    wait_pe(0, 30, found);
    n_checks++; if (!found) $display("FAIL edge_first_pe: got timeout expected pulse"); else n_pass++;
    hi = 0; pe_n = 0; pe_at = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      hi += int'(o_pwm_out[0]);
      if (o_period_end[0]) begin pe_n++; pe_at = i; end
      n_checks++; if (o_pwm_out !== m_out) $display("FAIL edge_model: got %b expected %b", o_pwm_out, m_out); else n_pass++;
    end
    n_checks++; if (hi != 3) $display("FAIL edge_high_cycles: got %0d expected 3", hi); else n_pass++;
    n_checks++; if (pe_n != 1 || pe_at != 10) $display("FAIL edge_pe_spacing: got %0d pulses last at %0d expected 1 at 10", pe_n, pe_at); else n_pass++;
  endtask

  task automatic test_center_mode();
    bit found; int pe_at; logic [7:0] pat;
    do_reset(); setup_ch(1, 4, 2, 1, 0);
    i_enable = 1'b1;
    wait_pe(1, 30, found);
    n_checks++; if (!found) $display("FAIL center_first_pe: got timeout expected pulse"); else n_pass++;
    pe_at = 0; pat = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      pat[i-1] = o_pwm_out[1];
      if (o_period_end[1]) pe_at = i;
    end
    n_checks++; if (pat !== 8'b1100_0001) $display("FAIL center_pattern: got %b expected 11000001", pat); else n_pass++;
    n_checks++; if (pe_at != 8) $display("FAIL center_pe_spacing: got %0d expected 8", pe_at); else n_pass++;
  endtask

  task automatic test_shadow_update();
    bit found; int hi;
    do_reset(); setup_ch(0, 9, 3, 0, 0);
    i_enable = 1'b1;
    wait_pe(0, 30, found);
    for (int i = 0; i < 4; i++) cycle();
    write_cfg(0, 1, 7);
    n_checks++; if (o_pending[0] !== 1'b1) $display("FAIL shadow_pending_set: got %b expected 1", o_pending[0]); else n_pass++;
    hi = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (o_period_end[0]) found = 1'b1; else hi += int'(o_pwm_out[0]);
    end
    n_checks++; if (!found) $display("FAIL shadow_pe: got timeout expected pulse"); else n_pass++;
    n_checks++; if (hi != 0) $display("FAIL shadow_old_duty_kept: got %0d high expected 0", hi); else n_pass++;
    n_checks++; if (o_pending[0] !== 1'b0) $display("FAIL shadow_pending_clr: got %b expected 0", o_pending[0]); else n_pass++;
    hi = 0;
    for (int i = 1; i <= 10; i++) begin cycle(); hi += int'(o_pwm_out[0]); end
    n_checks++; if (hi != 7) $display("FAIL shadow_new_duty: got %0d expected 7", hi); else n_pass++;
  endtask

  task automatic test_boundaries();
    bit found; int hi;
    do_reset(); setup_ch(0, 9, 0, 0, 0);
    i_enable = 1'b1; hi = 0;
    for (int i = 0; i < 25; i++) begin cycle(); hi += int'(o_pwm_out[0]); end
    n_checks++; if (hi != 0) $display("FAIL duty0_const_low: got %0d high expected 0", hi); else n_pass++;
    setup_ch(0, 9, 10, 0, 0);
    i_enable = 1'b1; hi = 0;
    for (int i = 0; i < 25; i++) begin cycle(); hi += int'(o_pwm_out[0]); end
    n_checks++; if (hi != 25) $display("FAIL duty10_const_high: got %0d high expected 25", hi); else n_pass++;
    setup_ch(0, 9, 3, 2, 0);
    i_enable = 1'b1;
    wait_pe(0, 30, found);
    hi = 0;
    for (int i = 1; i <= 10; i++) begin cycle(); hi += int'(o_pwm_out[0]); end
    n_checks++; if (hi != 7) $display("FAIL invert_high_cycles: got %0d expected 7", hi); else n_pass++;
    write_cfg(9, 1, 5);
    write_cfg(9, 0, 2);
    n_checks++; if (o_pending !== 4'b0000) $display("FAIL bad_ch_pending: got %b expected 0000", o_pending); else n_pass++;
    wait_pe(0, 30, found);
    hi = 0;
    for (int i = 1; i <= 10; i++) begin cycle(); hi += int'(o_pwm_out[0]); end
    n_checks++; if (hi != 7) $display("FAIL bad_ch_no_change: got %0d expected 7", hi); else n_pass++;
  endtask

  task automatic test_prescale_enable();
    bit found; int hi, pe_at;
    do_reset(); setup_ch(0, 9, 3, 0, 3);
    i_enable = 1'b1;
    wait_pe(0, 100, found);
    n_checks++; if (!found) $display("FAIL prescale_first_pe: got timeout expected pulse"); else n_pass++;
    hi = 0; pe_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      hi += int'(o_pwm_out[0]);
      if (o_period_end[0] && pe_at == 0) pe_at = i;
    end
    n_checks++; if (hi != 12) $display("FAIL prescale_high_cycles: got %0d expected 12", hi); else n_pass++;
    n_checks++; if (pe_at != 40) $display("FAIL prescale_period: got %0d expected 40", pe_at); else n_pass++;
    for (int i = 0; i < 2; i++) cycle();
    i_enable = 1'b0;
    cycle();
    n_checks++; if (o_pwm_out !== 4'b0000) $display("FAIL disable_inactive: got %b expected 0000", o_pwm_out); else n_pass++;
    n_checks++; if (o_period_end !== 4'b0000) $display("FAIL disable_no_pe: got %b expected 0000", o_period_end); else n_pass++;
    write_cfg(0, 2, 2);
    cycle(); cycle();
    n_checks++; if (o_pwm_out[0] !== 1'b1) $display("FAIL disable_inactive_inv: got %b expected 1", o_pwm_out[0]); else n_pass++;
    i_enable = 1'b1; pe_at = 0;
    for (int i = 1; i <= 45 && pe_at == 0; i++) begin
      cycle();
      if (o_period_end[0]) pe_at = i;
    end
    n_checks++; if (pe_at != 40) $display("FAIL reenable_from_zero: got %0d expected 40", pe_at); else n_pass++;
  endtask

  task automatic test_rst_mid_run();
    do_reset(); setup_ch(0, 9, 3, 2, 0);
    i_enable = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    rst = 1'b1; i_cfg_we = 1'b1; i_cfg_ch = 4'd1; i_cfg_sel = 2'd1; i_cfg_wdata = 16'd4;
    cycle();
    rst = 1'b0; i_cfg_we = 1'b0; i_enable = 1'b0;
    n_checks++; if (o_pwm_out !== 4'b0000) $display("FAIL rst_mid_pwm: got %b expected 0000", o_pwm_out); else n_pass++;
    n_checks++; if (o_pending !== 4'b0000) $display("FAIL rst_mid_pending: got %b expected 0000", o_pending); else n_pass++;
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    i_enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 2) i_enable = ~i_enable;
      i_cfg_we = ($urandom_range(0, 9) == 0);
      i_cfg_ch = 4'($urandom_range(0, 5));
      sel = $urandom_range(0, 3);
      i_cfg_sel = 2'(sel);
      case (sel)
        0: i_cfg_wdata = 16'($urandom_range(0, 12));
        1: i_cfg_wdata = 16'($urandom_range(0, 14));
        2: i_cfg_wdata = 16'($urandom_range(0, 3));
        default: i_cfg_wdata = 16'($urandom_range(0, 2));
      endcase
      cycle();
      n_checks++; if (o_pwm_out !== m_out) $display("FAIL rand_pwm @%0d: got %b expected %b", i, o_pwm_out, m_out); else n_pass++;
      n_checks++; if (o_period_end !== m_pe) $display("FAIL rand_pe @%0d: got %b expected %b", i, o_period_end, m_pe); else n_pass++;
      n_checks++; if (o_pending !== m_pend) $display("FAIL rand_pending @%0d: got %b expected %b", i, o_pending, m_pend); else n_pass++;
    end
    rst = 1'b0; i_cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_cfg_we = 1'b0;
    i_cfg_ch = 4'd0; i_cfg_sel = 2'd0; i_cfg_wdata = 16'd0;
    test_reset();
    test_edge_mode();
    test_center_mode();
    test_shadow_update();
    test_boundaries();
    test_prescale_enable();
    test_rst_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
